// File: rtl/coletor_digitos.sv
// Keypad digit collector: builds up to a 20-digit entry, newest digit at index 0,
// and emits it as a one-cycle strobe on '*' (confirm) or '#' (cancel).
module coletor_digitos #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  key_value,
    input  logic        key_valid,
    output logic [79:0] digitos_value,
    output logic        digitos_valid,
    output logic [23:0] bcd_pac,
    output logic        display_en
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] COLETA = 2'd1;
    localparam logic [1:0] ENVIA  = 2'd2;

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [79:0] EMPTY  = {20{4'hF}};
    localparam logic [79:0] CANCEL = {20{4'hB}};

    logic [1:0]    state, state_nxt;
    logic [79:0]   buffer, buffer_nxt;
    logic [79:0]   out_reg, out_reg_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic is_digit, is_conf, is_skip, buf_empty;

    assign is_digit  = (key_value <= 4'd9);
    assign is_conf   = (key_value == 4'hA);
    assign is_skip   = (key_value == 4'hB);
    // Only digits are ever shifted in, so the newest slot tells emptiness.
    assign buf_empty = (buffer[3:0] == 4'hF);

    always_comb begin
        state_nxt   = state;
        buffer_nxt  = buffer;
        out_reg_nxt = out_reg;
        cnt_nxt     = cnt;
        case (state)
            IDLE: begin
                buffer_nxt = EMPTY;
                cnt_nxt    = '0;
                if (enable)
                    state_nxt = COLETA;
            end
            COLETA: begin
                if (!enable) begin
                    state_nxt  = IDLE;
                    buffer_nxt = EMPTY;
                    cnt_nxt    = '0;
                end else if (key_valid && is_digit) begin
                    // Sliding window: the oldest digit falls off the top.
                    buffer_nxt = {buffer[75:0], key_value};
                    cnt_nxt    = '0;
                end else if (key_valid && is_conf && !buf_empty) begin
                    out_reg_nxt = buffer;
                    buffer_nxt  = EMPTY;
                    cnt_nxt     = '0;
                    state_nxt   = ENVIA;
                end else if (key_valid && is_skip) begin
                    out_reg_nxt = CANCEL;
                    buffer_nxt  = EMPTY;
                    cnt_nxt     = '0;
                    state_nxt   = ENVIA;
                end else if (buf_empty) begin
                    cnt_nxt = '0;
                end else if (cnt == CNT_LAST) begin
                    // Idle too long: silently drop the partial entry.
                    buffer_nxt = EMPTY;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            ENVIA: begin
                buffer_nxt = EMPTY;
                cnt_nxt    = '0;
                state_nxt  = enable ? COLETA : IDLE;
            end
            default: begin
                state_nxt  = IDLE;
                buffer_nxt = EMPTY;
                cnt_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            buffer  <= EMPTY;
            out_reg <= EMPTY;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            buffer  <= buffer_nxt;
            out_reg <= out_reg_nxt;
            cnt     <= cnt_nxt;
        end
    end

    assign digitos_valid = (state == ENVIA);
    assign digitos_value = (state == ENVIA) ? out_reg : buffer;
    assign bcd_pac       = (state == IDLE) ? 24'hFFFFFF : buffer[23:0];
    assign display_en    = enable && !buf_empty;

endmodule

// File: doc/coletor_digitos.md
COLETOR_DIGITOS -- requirements
Module: coletor_digitos

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 5000, the number of idle clock cycles after which a partial entry is discarded.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port enable, input, 1, collection enabled; low means buffer held cleared.
REQ-005 SHALL have port key_value, input, 4, keypad code: 0-9 digit, 4'hA '*' (confirm), 4'hB '#' (skip/cancel), 4'hC-4'hF unused.
REQ-006 SHALL have port key_valid, input, 1, one-cycle strobe qualifying key_value.
REQ-007 SHALL have port digitos_value, output, senhaPac_t (20 nibbles), the packed entry: index 0 is the newest digit, and 4'hF marks an empty position.
REQ-008 SHALL have port digitos_valid, output, 1, one-cycle strobe qualifying digitos_value.
REQ-009 SHALL have port bcd_pac, output, bcdPac_t, echo of the entry: BCD0..BCD5 equal buffer[0..5].
REQ-010 SHALL have port display_en, output, 1, high while enable is high and the buffer is non-empty.

Function
REQ-011 SHALL implement states IDLE, COLETA and ENVIA.
REQ-012 IDLE: SHALL go to COLETA when enable=1, and SHALL ignore all keys while in IDLE.
REQ-013 COLETA: on key_valid with a digit 0-9, SHALL shift the buffer up one position (buffer[i+1]<=buffer[i], buffer[0]<=key) and discard buffer[19].
REQ-014 With 20 digits already stored, a further digit SHALL drop the oldest digit (sliding window); there is no error and no stall.
REQ-015 COLETA: '*' with a non-empty buffer SHALL load the output register with the buffer, clear the buffer to all 4'hF, and go to ENVIA.
REQ-016 '*' with an empty buffer SHALL be ignored: no strobe and no state change.
REQ-017 COLETA: '#' SHALL load the output register with {20{4'hB}}, clear the buffer, and go to ENVIA, regardless of buffer contents.
REQ-018 Codes 4'hC-4'hF SHALL be ignored and SHALL NOT restart the timeout.
REQ-019 ENVIA: digitos_valid=1 for exactly one cycle, with digitos_value equal to the captured value; the next state SHALL be COLETA (or IDLE if enable=0).
REQ-020 A key_valid arriving in ENVIA SHALL be dropped.
REQ-021 Outside ENVIA, digitos_value SHALL show the live buffer, and digitos_valid SHALL be 0.
REQ-022 Latency: a confirming key at edge N SHALL produce digitos_valid high during the cycle after edge N (registered, 1 cycle).
REQ-023 Timeout counter: SHALL reset to 0 on every accepted key (0-9, A, B), and SHALL increment each cycle in COLETA while the buffer is non-empty.
REQ-024 Timeout: on reaching TIMEOUT_CYCLES-1 the buffer SHALL clear to all 4'hF and the counter SHALL return to 0; no strobe is issued.
REQ-025 Timeout and key_valid in the same cycle: the key SHALL win; it is processed and the counter resets.
REQ-026 The counter SHALL be wide enough for TIMEOUT_CYCLES, SHALL saturate-free wrap to 0 only via REQ-024, and SHALL hold 0 while the buffer is empty.
REQ-027 enable falling in any state: the next edge SHALL go to IDLE, clear the buffer and counter, and force digitos_valid=0; a pending ENVIA already in progress completes its single cycle first.
REQ-028 bcd_pac SHALL be combinational from the live buffer; in IDLE all BCD fields SHALL be 4'hF.

Reset
REQ-029 rst=1 SHALL asynchronously force state IDLE, buffer all 4'hF, output register all 4'hF, counter 0.
REQ-030 Under reset, outputs SHALL be: digitos_valid=0, digitos_value all 4'hF, bcd_pac all 4'hF, display_en=0.
REQ-031 Reset asserted mid-entry or during ENVIA SHALL abort without a strobe; after release, the first edge with enable=1 SHALL enter COLETA.

Verification
REQ-032 enable=1; keys 1,2,3,4,* -> one-cycle digitos_valid with digitos_value = {16{F},1,2,3,4} ([0]=4); the next cycle is all F.
REQ-033 Key # alone -> digitos_valid with {20{4'hB}}; key * alone on an empty buffer -> no strobe.
REQ-034 Keys 0..9 repeated to total 22 digits, then * -> the 20 most recent digits, oldest two dropped; bcd_pac during entry shows the last 6 digits.
REQ-035 TIMEOUT_CYCLES=8; key 5, then idle 8 cycles -> buffer all F, no strobe; repeat with a key on the expiry cycle -> the key is retained and the counter restarts.
REQ-036 Keys 7,8 then rst pulse mid-cycle -> immediate all-F outputs, no strobe; after release, keys 9,* -> {19{F},9}.
REQ-037 Key * then enable=0 on the ENVIA cycle -> single strobe still issued, then IDLE; keys in IDLE are ignored.
